// File: rtl/pq_pkg.sv
// Shared priority-queue types: key-value record, capacity, client op codes and
// the client arbiter's state encoding.
package pq_pkg;

    localparam int KEY_W       = 8;
    localparam int VAL_W       = 8;
    localparam int PQ_CAPACITY = 4;
    localparam int CNT_W       = $clog2(PQ_CAPACITY) + 1;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } kv_t;

    localparam logic [KEY_W-1:0] KEY0 = '0;
    localparam logic [VAL_W-1:0] VAL0 = '0;
    localparam kv_t              KV0  = '{key: KEY0, val: VAL0};

    // 2'b00 is deliberately unnamed: it is the illegal encoding.
    typedef enum logic [1:0] {
        OP_ENQ  = 2'b01,
        OP_DEQ  = 2'b10,
        OP_REPL = 2'b11
    } pq_op_t;

    typedef enum logic [2:0] {
        ST_ARB,
        ST_ISSUE,
        ST_SETTLE,
        ST_WAIT,
        ST_ACK
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    // Scan farthest-to-nearest so the last hit is the closest to rr_ptr.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                gnt_idx   = IW'(j);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pq_client_arb.sv
// Shares one priority-queue device among N clients: round-robin grant, legality
// check, single-cycle command pulse, busy wait and per-client ack with result.
module pq_client_arb
    import pq_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  pq_op_t [N-1:0]       op,
    input  kv_t [N-1:0]          kv_in,
    output logic [N-1:0]         ack,
    output kv_t                  kv_out,
    output logic                 err,
    output logic [CNT_W-1:0]     count,
    output logic                 pq_enq,
    output logic                 pq_deq,
    output kv_t                  pq_kvi,
    input  kv_t                  pq_kvo,
    input  logic                 pq_full,
    input  logic                 pq_empty,
    input  logic                 pq_busy
);

    arb_state_t       state_q;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    gidx_q;
    pq_op_t           gop_q;
    kv_t              gkv_q, res_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_valid;
    logic             legal, issue;

    rr_arbiter #(.N(N)) u_rr (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        legal = 1'b0;
        case (gop_q)
            OP_ENQ:          legal = !pq_full;
            OP_DEQ, OP_REPL: legal = !pq_empty;
            default:         legal = 1'b0;
        endcase
    end

    assign issue  = (state_q == ST_ISSUE) && legal;
    assign pq_enq = issue && gop_q[0];
    assign pq_deq = issue && gop_q[1];
    assign pq_kvi = issue ? gkv_q : KV0;

    // res_q is cleared at grant, so ENQ and rejected acks return {KEY0,VAL0}.
    assign kv_out = (state_q == ST_ACK) ? res_q : KV0;
    assign err    = (state_q == ST_ACK) && err_q;
    assign count  = count_q;

    always_comb begin
        ack = '0;
        for (int i = 0; i < N; i++)
            ack[i] = (state_q == ST_ACK) && (gidx_q == IW'(i));
    end

    always_comb begin
        count_d = count_q;
        if (!err_q) begin
            case (gop_q)
                OP_ENQ:  count_d = count_q + 1'b1;
                OP_DEQ:  count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        rr_ptr_d = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            gop_q    <= pq_op_t'(2'b00);
            gkv_q    <= KV0;
            res_q    <= KV0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (!pq_busy && gnt_valid) begin
                        gidx_q  <= gnt_idx;
                        gop_q   <= op[gnt_idx];
                        gkv_q   <= kv_in[gnt_idx];
                        res_q   <= KV0;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!legal) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end else begin
                        if (gop_q[1]) res_q <= pq_kvo;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: state_q <= ST_WAIT;
                ST_WAIT:   if (!pq_busy) state_q <= ST_ACK;
                ST_ACK: begin
                    count_q  <= count_d;
                    rr_ptr_q <= rr_ptr_d;
                    err_q    <= 1'b0;
                    state_q  <= ST_ARB;
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

endmodule

// File: doc/pq_client_arb.md
# pq_client_arb

Round-robin controller that shares one priority-queue device (heap or other `pq_if` implementation) among `N` independent clients. It accepts one request at a time and checks it against full/empty. It then sequences the single-cycle `enq`/`deq` command pulse, waits out the device's multi-cycle `busy` period, and returns the dequeued key-value pair plus an error flag to the granted client. It sits between client logic (schedulers, event queues) and the PQ device's `dev` modport.

## Interface
Parameters:
- `N`, default 4: number of clients; `IW = (N>1) ? $clog2(N) : 1`.

Ports (`kv_t`, `pq_op_t` and the `KEY0`/`VAL0` constants come from `pq_pkg`):
- `clk`  in  1  clock; rst is synchronous, active-high; clock clk.
- `rst`  in  1  synchronous active-high reset; also drives the PQ device reset.
- `req`  in  N  per-client request; held high until `ack`.
- `op`  in  N x pq_op_t  per-client operation, stable while `req` is high.
- `kv_in`  in  N x kv_t  per-client key-value to enqueue.
- `ack`  out  N  one-cycle completion pulse to the granted client.
- `kv_out`  out  kv_t  result (dequeued head); valid only in the `ack` cycle.
- `err`  out  1  rejection flag; valid in the `ack` cycle.
- `count`  out  $clog2(PQ_CAPACITY)+1  mirrored occupancy.
- `pq_enq`, `pq_deq`  out  1  command pulses to the device.
- `pq_kvi`  out  kv_t  key-value to the device.
- `pq_kvo`  in  kv_t  device head; valid when not empty and not busy.
- `pq_full`, `pq_empty`, `pq_busy`  in  1  device status.

## Operation
- Op encoding: `OP_ENQ`=01, `OP_DEQ`=10, `OP_REPL`=11 (both pulses, replace head); 00 is illegal.
- FSM states: ARB, ISSUE, SETTLE, WAIT, ACK.
- **ARB:** if `!pq_busy && |req`, pick the round-robin winner starting at `rr_ptr`. Latch `gidx`, `gop`, `gkv`, then go to ISSUE. Otherwise stay in ARB.
- **ISSUE:** check legality.
  - Illegal cases: op 00; ENQ with `pq_full`; DEQ or REPL with `pq_empty`.
  - Illegal: set `err_r`=1, issue no pulse, go to ACK.
  - Legal: assert `pq_enq` and/or `pq_deq` for exactly this cycle, with `pq_kvi=gkv`. For DEQ/REPL, capture `pq_kvo` into `res_r` in this cycle. Go to SETTLE.
- **SETTLE:** one unconditional cycle that absorbs the device's `busy` rise latency. Go to WAIT.
- **WAIT:** stay until `pq_busy==0`, then go to ACK.
- **ACK:**
  - `ack[gidx]`=1; `kv_out`=`res_r`; `err`=`err_r`.
  - `count` update: ENQ +1, DEQ −1, REPL unchanged; no change when `err`.
  - `rr_ptr`=`gidx+1`, wrapping from N−1 to 0.
  - Clear `err_r`, then go to ARB.
- `kv_out` holds `{KEY0,VAL0}` outside ACK, and for ENQ or error acks.
- Client handshake: a client may keep `req` high after `ack` to start a new op. It is sampled in the next ARB cycle, and round-robin rotation still applies.
- Changing `op` or `kv_in` while `req` is high and not yet granted is allowed. Only the values sampled in ARB are used.

## Timing
- Reset values:
  - state=ARB, `rr_ptr`=0, `count`=0.
  - `ack`=0, `err`=0, `pq_enq`=`pq_deq`=0.
  - `pq_kvi`=`kv_out`={KEY0,VAL0}.
- Minimum latency from `req` to `ack` is 4 cycles plus the device busy time: ARB, ISSUE, SETTLE, WAIT (≥1 cycle), ACK.
- Error path latency is 3 cycles (ARB, ISSUE, ACK).
- At most one outstanding device operation; `pq_enq`/`pq_deq` are never asserted outside ISSUE.
- Simultaneous requests: exactly one grant per ARB cycle; no client waits more than N−1 grants.
- `count` saturates at neither bound: the legality checks keep it within 0..PQ_CAPACITY by construction.
- Reset asserted mid-operation: everything returns to reset values on the next edge. No `ack` is emitted for the aborted request; the client must re-request.

## Structure
- `pq_pkg` additions: `pq_op_t` enum (2 bits, values above).
- `pq_pkg` already provides `kv_t`, `KEY0`, `VAL0`, `PQ_CAPACITY`.
- Sub-module `rr_arbiter #(N)`: combinational round-robin grant.
  - Inputs: `req`, `rr_ptr`.
  - Outputs: `gnt_idx`, `gnt_valid`.
- FSM, latches and `count` live in `pq_client_arb`.

## Test plan
- Single client, N=4: client 2 ENQ key 5, then DEQ. Required: ack[2] twice, second `kv_out.key`=5, `err`=0, `count` 0→1→0.
- Round-robin: all four clients ENQ simultaneously. Required: grants in order 0,1,2,3, keys 10,20,30,40. Then all DEQ: `kv_out` keys 10,20,30,40 in grant order 0..3.
- Empty error: DEQ on an empty PQ. Required: ack 3 cycles after req, `err`=1, no `pq_deq` pulse, `count`=0.
- Full error: fill to PQ_CAPACITY, then one more ENQ. Required: `err`=1, no `pq_enq` pulse, `count`=PQ_CAPACITY.
- Replace: contents {3,8}, REPL key 6. Required: `kv_out.key`=3 and a single cycle with `pq_enq` and `pq_deq` both high. A following DEQ returns 6, `count` ends at 1.
- Reset in WAIT: assert `rst` during a long busy period. Required: no ack, `count`=0, ARB state; a following ENQ/DEQ pair works.
